// File: rtl/fft_input_loader.sv
// fft_input_loader: collects 8 complex samples into a frame and presents them to butterfly1.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; a sample is consumed when both are high at a rising edge
//   in_sof                marks sample 0 of a frame; restarts a partial frame and flags frame_err
//   in_real, in_imag      signed sample components, DATA_W bits each
//   ifft_mode             conjugate the frame; latched on the frame's first sample
//   clr_err               synchronous clear of frame_err (a same-cycle truncation wins)
//   fft_d1..8_real/imag   frame outputs, held stable until the next frame is emitted
//   fft_data_valid        one-cycle pulse when the frame outputs are new
//   frame_err             sticky truncated-frame flag
//   frame_cnt             count of emitted frames, wraps at 256
module fft_input_loader #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic                     ifft_mode,
    input  logic                     clr_err,
    output logic signed [DATA_W-1:0] fft_d1_real,
    output logic signed [DATA_W-1:0] fft_d1_imag,
    output logic signed [DATA_W-1:0] fft_d2_real,
    output logic signed [DATA_W-1:0] fft_d2_imag,
    output logic signed [DATA_W-1:0] fft_d3_real,
    output logic signed [DATA_W-1:0] fft_d3_imag,
    output logic signed [DATA_W-1:0] fft_d4_real,
    output logic signed [DATA_W-1:0] fft_d4_imag,
    output logic signed [DATA_W-1:0] fft_d5_real,
    output logic signed [DATA_W-1:0] fft_d5_imag,
    output logic signed [DATA_W-1:0] fft_d6_real,
    output logic signed [DATA_W-1:0] fft_d6_imag,
    output logic signed [DATA_W-1:0] fft_d7_real,
    output logic signed [DATA_W-1:0] fft_d7_imag,
    output logic signed [DATA_W-1:0] fft_d8_real,
    output logic signed [DATA_W-1:0] fft_d8_imag,
    output logic                     fft_data_valid,
    output logic                     frame_err,
    output logic [7:0]               frame_cnt
);
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic {FILL, EMIT} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic                      mode_q, mode_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic [7:0]                cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  buf_re_q [8];
    logic signed [DATA_W-1:0]  buf_re_d [8];
    logic signed [DATA_W-1:0]  buf_im_q [8];
    logic signed [DATA_W-1:0]  buf_im_d [8];
    logic signed [DATA_W-1:0]  out_re_q [8];
    logic signed [DATA_W-1:0]  out_re_d [8];
    logic signed [DATA_W-1:0]  out_im_q [8];
    logic signed [DATA_W-1:0]  out_im_d [8];
    logic                      hs, restart, emit, mode_eff;
    logic [2:0]                slot;
    logic signed [DATA_W-1:0]  im_conj;

    always_comb begin
        hs       = in_valid && ready_q && (state_q == FILL);
        restart  = hs && in_sof && (idx_q != 3'd0);
        // a restarting sof sample lands in slot 0 and re-latches the mode
        slot     = restart ? 3'd0 : idx_q;
        mode_eff = (slot == 3'd0) ? ifft_mode : mode_q;
        // the most negative value has no positive twin, so it saturates
        im_conj  = (in_imag == MIN_V) ? MAX_V : -in_imag;
        emit     = hs && (slot == 3'd7);
        buf_re_d = buf_re_q;
        buf_im_d = buf_im_q;
        if (hs) begin
            buf_re_d[slot] = in_real;
            buf_im_d[slot] = mode_eff ? im_conj : in_imag;
        end
        // slot 7 reaches the outputs straight from the current sample via buf_*_d
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        if (emit) begin
            out_re_d = buf_re_d;
            out_im_d = buf_im_d;
        end
        mode_d   = hs ? mode_eff : mode_q;
        idx_d    = hs ? slot + 3'd1 : idx_q;
        state_d  = emit ? EMIT : FILL;
        ready_d  = !emit;
        valid_d  = emit;
        err_d    = restart || (err_q && !clr_err);
        cnt_d    = emit ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            idx_q    <= 3'd0;
            mode_q   <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            buf_re_q <= '{default: '0};
            buf_im_q <= '{default: '0};
            out_re_q <= '{default: '0};
            out_im_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            buf_re_q <= buf_re_d;
            buf_im_q <= buf_im_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    assign in_ready       = ready_q;
    assign fft_data_valid = valid_q;
    assign frame_err      = err_q;
    assign frame_cnt      = cnt_q;
    assign fft_d1_real    = out_re_q[0];
    assign fft_d1_imag    = out_im_q[0];
    assign fft_d2_real    = out_re_q[1];
    assign fft_d2_imag    = out_im_q[1];
    assign fft_d3_real    = out_re_q[2];
    assign fft_d3_imag    = out_im_q[2];
    assign fft_d4_real    = out_re_q[3];
    assign fft_d4_imag    = out_im_q[3];
    assign fft_d5_real    = out_re_q[4];
    assign fft_d5_imag    = out_im_q[4];
    assign fft_d6_real    = out_re_q[5];
    assign fft_d6_imag    = out_im_q[5];
    assign fft_d7_real    = out_re_q[6];
    assign fft_d7_imag    = out_im_q[6];
    assign fft_d8_real    = out_re_q[7];
    assign fft_d8_imag    = out_im_q[7];
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: randomized and directed checks of fft_input_loader against a frame-level model.
module tb_fft_input_loader;
    logic               clk;
    logic               rst_n;
    logic               in_valid, in_sof, ifft_mode, clr_err;
    logic               in_ready, fft_data_valid, frame_err;
    logic signed [31:0] in_real, in_imag;
    logic [7:0]         frame_cnt;
    logic signed [31:0] d1r, d1i, d2r, d2i, d3r, d3i, d4r, d4i;
    logic signed [31:0] d5r, d5i, d6r, d6i, d7r, d7i, d8r, d8i;

    fft_input_loader #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag), .ifft_mode(ifft_mode), .clr_err(clr_err),
        .fft_d1_real(d1r), .fft_d1_imag(d1i), .fft_d2_real(d2r), .fft_d2_imag(d2i),
        .fft_d3_real(d3r), .fft_d3_imag(d3i), .fft_d4_real(d4r), .fft_d4_imag(d4i),
        .fft_d5_real(d5r), .fft_d5_imag(d5i), .fft_d6_real(d6r), .fft_d6_imag(d6i),
        .fft_d7_real(d7r), .fft_d7_imag(d7i), .fft_d8_real(d8r), .fft_d8_imag(d8i),
        .fft_data_valid(fft_data_valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // frame-level model: samples accepted so far in the current frame
    logic signed [31:0] q_re[$];
    logic signed [31:0] q_im[$];
    logic               m;
    logic signed [31:0] exp_re[8];
    logic signed [31:0] exp_im[8];
    logic               exp_ready, exp_valid, exp_err;
    logic [7:0]         exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic signed [31:0] neg_sat(input logic signed [31:0] x);
        longint t;
        t = -longint'(x);
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        return t[31:0];
    endfunction

    task automatic model_reset;
        q_re.delete();
        q_im.delete();
        m = 1'b0;
        exp_ready = 1'b0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 8'd0;
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = 0;
            exp_im[k] = 0;
        end
    endtask

    task automatic model_edge;
        bit acc, rs;
        acc = in_valid && exp_ready;
        rs = acc && in_sof && (q_re.size() != 0);
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        if (rs) begin
            q_re.delete();
            q_im.delete();
        end
        if (acc) begin
            if (q_re.size() == 0) m = ifft_mode;
            q_re.push_back(in_real);
            q_im.push_back(m ? neg_sat(in_imag) : in_imag);
            if (q_re.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    exp_re[k] = q_re[k];
                    exp_im[k] = q_im[k];
                end
                q_re.delete();
                q_im.delete();
                exp_valid = 1'b1;
                exp_ready = 1'b0;
                exp_cnt = exp_cnt + 8'd1;
            end
        end
        exp_err = rs ? 1'b1 : (clr_err ? 1'b0 : exp_err);
    endtask

    task automatic check_all;
        logic signed [31:0] r[8];
        logic signed [31:0] i[8];
        r = '{d1r, d2r, d3r, d4r, d5r, d6r, d7r, d8r};
        i = '{d1i, d2i, d3i, d4i, d5i, d6i, d7i, d8i};
        chk("in_ready", in_ready, exp_ready);
        chk("fft_data_valid", fft_data_valid, exp_valid);
        chk("frame_err", frame_err, exp_err);
        chk("frame_cnt", frame_cnt, exp_cnt);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("d%0d_real", k + 1), r[k], exp_re[k]);
            chk($sformatf("d%0d_imag", k + 1), i[k], exp_im[k]);
        end
    endtask

    task automatic step(input logic v, input logic sof, input logic signed [31:0] re,
                        input logic signed [31:0] im, input logic md, input logic clr);
        in_valid = v;
        in_sof = sof;
        in_real = re;
        in_imag = im;
        ifft_mode = md;
        clr_err = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle;
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int base, input logic md);
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, base + k, -(base + k), md, 1'b0);
    endtask

    task automatic async_reset;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        logic signed [31:0] rim;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_real = 0;
        in_imag = 0;
        ifft_mode = 1'b0;
        clr_err = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle();
        chk("ready_after_reset", in_ready, 1'b1);

        // natural order, continuous valid
        frame(1, 1'b0);
        chk("nat_valid", fft_data_valid, 1'b1);
        chk("nat_ready_low", in_ready, 1'b0);
        chk("nat_d1_re", d1r, 1);
        chk("nat_d1_im", d1i, -1);
        chk("nat_d8_re", d8r, 8);
        chk("nat_d8_im", d8i, -8);
        chk("nat_cnt", frame_cnt, 1);
        idle();
        chk("nat_ready_back", in_ready, 1'b1);
        chk("nat_hold_d8", d8i, -8);

        // conjugation latched at sample 0, ignored mid-frame, with saturation
        for (int k = 0; k < 8; k++)
            step(1'b1, k == 0, k, (k == 6) ? 32'sh80000000 : 5, k < 3, 1'b0);
        chk("conj_d1_im", d1i, -5);
        chk("conj_d5_im", d5i, -5);
        chk("conj_sat", d7i, 32'sh7fffffff);
        idle();

        // truncation with clr_err in the same cycle
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 10 + k, 1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 100, 7, 1'b0, 1'b1);
        chk("trunc_err_set_wins", frame_err, 1'b1);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 100 + k, 7, 1'b0, 1'b0);
        chk("trunc_valid", fft_data_valid, 1'b1);
        chk("trunc_d1_re", d1r, 100);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("trunc_err_clr", frame_err, 1'b0);

        // backpressure: A held through EMIT is taken once, as slot 0
        frame(20, 1'b0);
        step(1'b1, 1'b1, 555, -555, 1'b0, 1'b0);
        step(1'b1, 1'b1, 555, -555, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 600 + k, 0, 1'b0, 1'b0);
        chk("bp_valid", fft_data_valid, 1'b1);
        chk("bp_d1_re", d1r, 555);
        chk("bp_d2_re", d2r, 601);
        idle();

        // reset mid-frame, then a clean frame
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, 70 + k, 3, 1'b0, 1'b0);
        async_reset();
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_d1_re", d1r, 0);
        idle();
        frame(40, 1'b0);
        chk("rst_clean_cnt", frame_cnt, 1);
        chk("rst_clean_d1", d1r, 40);

        // reset during EMIT suppresses the pulse
        async_reset();
        chk("rst_emit_valid", fft_data_valid, 1'b0);
        idle();

        // 256 back-to-back frames wrap the counter
        pulses = 0;
        for (int c = 0; c < 256 * 9; c++) begin
            step(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
            if (fft_data_valid) pulses++;
        end
        chk("wrap_pulses", pulses, 256);
        chk("wrap_cnt", frame_cnt, 0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            rim = ($urandom_range(15) == 0) ? 32'sh80000000 : $urandom;
            step($urandom_range(3) != 0, $urandom_range(9) == 0, $urandom, rim,
                 $urandom_range(1) == 1, $urandom_range(15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32 (`instWidth), the signed two's-complement width of each real/imag component.
REQ-002 SHALL have clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have in_valid, input, 1: an upstream sample is present.
REQ-005 SHALL have in_ready, output, 1: the loader accepts a sample this cycle.
REQ-006 SHALL have in_sof, input, 1: the offered sample is sample 0 of a frame; meaningful only when in_valid is high.
REQ-007 SHALL have in_real and in_imag, input, DATA_W each, signed: the sample components.
REQ-008 SHALL have ifft_mode, input, 1: conjugate the frame, for IFFT computed through the FFT datapath.
REQ-009 SHALL have clr_err, input, 1: synchronous clear of frame_err.
REQ-010 SHALL have fft_dk_real and fft_dk_imag for k=1..8, output, DATA_W each: the frame presented to the butterfly1 stage.
REQ-011 SHALL have fft_data_valid, output, 1: the frame outputs are new this cycle.
REQ-012 SHALL have frame_err, output, 1: sticky flag for a truncated frame.
REQ-013 SHALL have frame_cnt, output, 8: count of emitted frames.

Function
REQ-014 SHALL define a handshake as in_valid && in_ready sampled at a rising edge; no other input sample is consumed.
REQ-015 SHALL implement two states, FILL and EMIT, with in_ready = 1 in FILL and in_ready = 0 in EMIT; all outputs SHALL be registered.
REQ-016 SHALL keep a 3-bit sample index idx, 0..7, and store handshaken sample idx into buffer slot idx, then increment idx.
REQ-017 SHALL latch ifft_mode on the handshake where idx = 0 and apply the latched value to the whole frame; mid-frame changes of ifft_mode SHALL have no effect.
REQ-018 SHALL, with latched ifft_mode = 1, store the imag component negated; -2^(DATA_W-1) SHALL saturate to 2^(DATA_W-1)-1. The real component SHALL be stored unchanged, with no other scaling.
REQ-019 SHALL, on the handshake at idx = 7:
- load fft_d(k)_real/imag from slot k-1 for k=1..8 in natural order, with slot 7 taken directly from the current sample;
- set idx to 0;
- enter EMIT.
REQ-020 SHALL hold fft_data_valid = 1 for exactly the one EMIT cycle, the cycle after the 8th handshake, then return to FILL unconditionally.
REQ-021 SHALL sustain a throughput of 8 samples per 9 cycles under continuous in_valid.
REQ-022 SHALL hold the frame outputs stable from one EMIT until the next EMIT.
REQ-023 SHALL, on a handshake with in_sof = 1 while idx != 0:
- discard the partial frame;
- store this sample as slot 0, with ifft_mode re-latched;
- set idx to 1;
- set frame_err to 1.
REQ-024 SHALL accept in_sof = 1 at idx = 0 as a normal frame start; frames without any in_sof SHALL be accepted.
REQ-025 SHALL clear frame_err on clr_err = 1 unless a REQ-023 event occurs in the same cycle, in which case set wins.
REQ-026 SHALL increment frame_cnt on entry to EMIT, wrapping 255 to 0.
REQ-027 SHALL ignore in_valid while in EMIT; the upstream must hold its sample until in_ready is seen high.

Reset
REQ-028 SHALL, while rst_n = 0, force all of the following regardless of clk:
- state = FILL, idx = 0, latched mode = 0;
- in_ready = 0, fft_data_valid = 0, frame_err = 0, frame_cnt = 0;
- every fft_dk_real/imag = 0.
REQ-029 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-030 SHALL, on reset mid-frame or in EMIT, discard the partial frame and suppress any pending fft_data_valid.

Verification
REQ-031 SHALL cover natural order: samples real=1..8, imag=-1..-8, ifft_mode=0, continuous valid.
- Required response: fft_data_valid pulses one cycle after the 8th handshake, with fft_d1=(1,-1) … fft_d8=(8,-8).
- frame_cnt reads 1; in_ready is low for that cycle only.
REQ-032 SHALL cover conjugation: ifft_mode=1 at sample 0, toggled to 0 at sample 3, imag=5 each, plus one sample with imag=-2^31.
- Required response: all outputs imag=-5, and the -2^31 sample yields 2^31-1.
REQ-033 SHALL cover truncation: in_sof re-asserted at sample 5, followed by 7 more samples.
- Required response: frame_err=1, and one frame emitted whose fft_d1 is the sof sample.
- With clr_err and truncation in the same cycle, frame_err stays 1.
REQ-034 SHALL cover backpressure: in_valid held through EMIT on sample A.
- Required response: A is accepted exactly once, in the cycle after EMIT, as slot 0 of the next frame.
REQ-035 SHALL cover reset: rst_n pulsed low asynchronously after 4 samples.
- Required response: all outputs go to 0 immediately.
- The next 8 samples form a clean frame; frame_cnt = 1.
REQ-036 SHALL cover wrap: 256 back-to-back frames.
- Required response: frame_cnt returns to 0, and fft_data_valid pulses every 9th cycle.
